// File: rtl/jtag_ram_arb.sv
// Single-port capture RAM arbiter: JTAG writer has priority, AXI-lite reads are protected by a starvation limit.
// Optional JTAG_ARB_STATS_EN adds stat_conflicts, a saturating count of cycles where both requesters were eligible.
module jtag_ram_arb #(
   parameter int AW         = 9,
   parameter int DW         = 32,
   parameter int RAM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          sclk,
   input  logic          reset,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ack,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
`ifdef JTAG_ARB_STATS_EN
   output logic [15:0]   stat_conflicts,
`endif
   output logic [1:0]    dbg_state,
   output logic          busy
);

   // Handshake: a requester raises req with stable addr/data and holds it until its ack pulse;
   // the ack cycle is the cycle the access is on the RAM pins, and the held req is ignored then.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_WR = 2'd1,
      GNT_RD = 2'd2
   } state_t;

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t             state, state_nxt;
   logic [3:0]         streak, streak_nxt;
   logic [RAM_LAT-1:0] vchain, vchain_nxt;
   logic               wr_elig, rd_elig;

   assign dbg_state = state;
   assign wr_ack    = (state == GNT_WR);
   assign rd_ack    = (state == GNT_RD);
   assign rd_valid  = vchain[RAM_LAT-1];
   assign rd_data   = rd_valid ? ram_rdata : '0;
   assign busy      = rd_ack | (|vchain);

   always_comb begin
      wr_elig    = wr_req && (state != GNT_WR);
      rd_elig    = rd_req && (state != GNT_RD);
      state_nxt  = IDLE;
      streak_nxt = streak;
      if (wr_elig && rd_elig) begin
         state_nxt = (streak == SMAX) ? GNT_RD : GNT_WR;
      end else if (wr_elig) begin
         state_nxt = GNT_WR;
      end else if (rd_elig) begin
         state_nxt = GNT_RD;
      end
      // Streak only measures how long a pending read has been passed over.
      if (!rd_req || state_nxt == GNT_RD) begin
         streak_nxt = '0;
      end else if (state_nxt == GNT_WR && streak != SMAX) begin
         streak_nxt = streak + 4'd1;
      end
      vchain_nxt    = vchain;
      vchain_nxt[0] = rd_ack;
      for (int i = 1; i < RAM_LAT; i++) begin
         vchain_nxt[i] = vchain[i-1];
      end
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         streak    <= '0;
         vchain    <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         state     <= state_nxt;
         streak    <= streak_nxt;
         vchain    <= vchain_nxt;
         ram_en    <= (state_nxt != IDLE);
         ram_we    <= (state_nxt == GNT_WR);
         ram_addr  <= (state_nxt == GNT_WR) ? wr_addr :
                      (state_nxt == GNT_RD) ? rd_addr : '0;
         ram_wdata <= (state_nxt == GNT_WR) ? wr_data : '0;
      end
   end

`ifdef JTAG_ARB_STATS_EN
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         stat_conflicts <= '0;
      end else if (wr_elig && rd_elig && stat_conflicts != 16'hFFFF) begin
         stat_conflicts <= stat_conflicts + 16'd1;
      end
   end
`endif

endmodule
